// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stall, redirect flush, forwarding selects.
// Optional define HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module pipeline_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_wr,
  input  logic              id_mem_rd,
  input  logic              ex_br_en,
  input  logic              ex_br_taken,
  output logic              stall,
  output logic              flush,
  output logic              redirect,
  output logic [1:0]        fwd_rs1,
  output logic [1:0]        fwd_rs2
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_wr;
    logic              load;
  } slot_t;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  slot_t      ex_q, mem_q, id_slot;
  logic       in_flush, hazard, accept;
  logic [1:0] sel1, sel2;

  // A slot is a producer for rs only if it really writes a non-x0 register.
  function automatic logic live(input slot_t s, input logic [REG_AW-1:0] rs);
    return s.valid & s.reg_wr & (s.rd != '0) & (s.rd == rs);
  endfunction

  function automatic logic [1:0] sel(input logic used, input logic [REG_AW-1:0] rs,
                                     input slot_t ex, input slot_t mem);
    if (!used)                     return 2'b00;
    if (live(ex, rs) && !ex.load)  return 2'b01;
    if (live(mem, rs))             return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    in_flush = (state_q == FLUSH);
    redirect = ex_br_en & ex_br_taken & ex_q.valid & ~in_flush;
    flush    = redirect | in_flush;
    hazard   = id_valid & ~in_flush & ex_q.load &
               ((id_rs1_used & live(ex_q, id_rs1)) | (id_rs2_used & live(ex_q, id_rs2)));
    // A redirect squashes the stalled instruction, so it wins.
    stall    = hazard & ~redirect;
    accept   = id_valid & ~stall & ~flush;
    id_slot  = '{valid: 1'b1, rd: id_rd, reg_wr: id_reg_wr, load: id_mem_rd};
    sel1     = sel(id_rs1_used, id_rs1, ex_q, mem_q);
    sel2     = sel(id_rs2_used, id_rs2, ex_q, mem_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN, STALL: begin
        if (redirect) begin
          state_d = FLUSH;
          cnt_d   = 2'(FLUSH_CYCLES - 1);
        end else if (stall) begin
          state_d = STALL;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (cnt_q == 2'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = RUN;
    endcase
  end

  // The MEM slot retires into WB and is dropped: the register file is
  // write-through, so nothing ever compares against an instruction in WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
      ex_q    <= '0;
      mem_q   <= '0;
      fwd_rs1 <= 2'b00;
      fwd_rs2 <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= accept ? id_slot : '0;
      mem_q   <= ex_q;
      fwd_rs1 <= accept ? sel1 : 2'b00;
      fwd_rs2 <= accept ? sel2 : 2'b00;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; forwarding expectations go through a queue one cycle deep.
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs1_used, id_rs2_used, id_reg_wr, id_mem_rd;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_br_en, ex_br_taken;
  logic       stall, flush, redirect;
  logic [1:0] fwd_rs1, fwd_rs2;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(5), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd),
    .ex_br_en(ex_br_en), .ex_br_taken(ex_br_taken),
    .stall(stall), .flush(flush), .redirect(redirect),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_reg_wr = 0; id_mem_rd = 0; ex_br_en = 0; ex_br_taken = 0;
  endtask

  // One pipeline cycle: compare last cycle's forwarding, drive ID/EX inputs,
  // compare combinational outputs, queue the forwarding expected next cycle.
  task automatic step(input int n, input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic wr, input logic ld, input logic bre, input logic brt,
                      input logic es, input logic ef, input logic er,
                      input logic [1:0] f1, input logic [1:0] f2);
    logic [3:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("s%0d fwd_rs1", n), 32'(fwd_rs1), 32'(e[3:2]));
      chk($sformatf("s%0d fwd_rs2", n), 32'(fwd_rs2), 32'(e[1:0]));
    end
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_reg_wr = wr; id_mem_rd = ld; ex_br_en = bre; ex_br_taken = brt;
    #1;
    chk($sformatf("s%0d stall", n),    32'(stall),    32'(es));
    chk($sformatf("s%0d flush", n),    32'(flush),    32'(ef));
    chk($sformatf("s%0d redirect", n), 32'(redirect), 32'(er));
    exp_q.push_back({f1, f2});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " stall"},    32'(stall),    32'd0);
    chk({tag, " flush"},    32'(flush),    32'd0);
    chk({tag, " redirect"}, 32'(redirect), 32'd0);
    chk({tag, " fwd_rs1"},  32'(fwd_rs1),  32'd0);
    chk({tag, " fwd_rs2"},  32'(fwd_rs2),  32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, " stall_cnt"}, stall_cnt, 32'd0);
    chk({tag, " flush_cnt"}, flush_cnt, 32'd0);
`endif
  endtask

  initial begin
    drive_idle();
    rst_n = 0;
    #12;
    chk_zero("reset");
    @(negedge clk); rst_n = 1;

    //  n  v rs1 u1 rs2 u2 rd wr ld bre brt | stall flush redir | fwd next
    step(1,  1, 1, 1, 2, 1, 5,  1, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00); // ADD x5,x1,x2
    step(2,  1, 5, 1, 1, 1, 6,  1, 0, 1, 0,  0, 0, 0, 2'b01, 2'b00); // ADD x6,x5,x1 (+untaken br)
    step(3,  1, 3, 1, 0, 0, 7,  1, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00); // LD x7,0(x3)
    step(4,  1, 7, 1, 7, 1, 8,  1, 0, 0, 0,  1, 0, 0, 2'b00, 2'b00); // ADD x8,x7,x7 stalls
    step(5,  1, 7, 1, 7, 1, 8,  1, 0, 0, 0,  0, 0, 0, 2'b10, 2'b10); // re-issue, load now in MEM
    step(6,  1, 0, 1, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00); // ADDI x0,x0,5
    step(7,  1, 0, 1, 0, 1, 9,  1, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00); // ADD x9,x0,x0
    step(8,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
    step(9,  1, 1, 1, 2, 1, 0,  0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00); // BEQ x1,x2
    step(10, 1, 1, 1, 2, 1, 10, 1, 0, 1, 1,  0, 1, 1, 2'b00, 2'b00); // taken -> redirect
    step(11, 1, 10,1, 10,1, 11, 1, 0, 1, 1,  0, 1, 0, 2'b00, 2'b00); // wrong-path br ignored
    step(12, 1, 11,1, 11,1, 12, 1, 0, 0, 0,  0, 1, 0, 2'b00, 2'b00);
    step(13, 1, 11,1, 12,1, 13, 1, 0, 1, 1,  0, 0, 0, 2'b00, 2'b00); // squashed rd not tracked
    step(14, 1, 1, 1, 0, 0, 14, 1, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00); // LD x14
    step(15, 1, 14,1, 2, 1, 15, 1, 0, 1, 1,  0, 1, 1, 2'b00, 2'b00); // load-use + redirect
    step(16, 1, 14,1, 14,1, 16, 1, 0, 0, 0,  0, 1, 0, 2'b00, 2'b00);
    step(17, 1, 14,1, 14,1, 16, 1, 0, 0, 0,  0, 1, 0, 2'b00, 2'b00);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf stall_cnt", stall_cnt, 32'd1);
    chk("perf flush_cnt", flush_cnt, 32'd5);
`endif

    // Reset pulse while still in FLUSH
    #2 rst_n = 0;
    #1 chk_zero("mid-flush reset");
    exp_q.delete();
    @(negedge clk); rst_n = 1;
    drive_idle();

    step(18, 1, 14,1, 14,1, 17, 1, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00); // RUN, no stale load
    step(19, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
    step(20, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
